// File: rtl/cmos_cfg_seq.sv
// CMOS sensor register-configuration sequencer: power-up delay, then one SCCB write per table entry with retry.
// Optional read-back verification of every write is enabled by defining CMOS_CFG_VERIFY_EN.
module cmos_cfg_seq #(
  parameter int REG_NUM   = 250,
  parameter int IDX_W     = 8,
  parameter int PWR_DLY   = 20000,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  output logic [IDX_W-1:0] cfg_index,
  input  logic [23:0]      cfg_data,
  output logic             i2c_exec,
  output logic             i2c_rh_wl,
  output logic [15:0]      i2c_addr,
  output logic [7:0]       i2c_data_w,
  input  logic [7:0]       i2c_data_r,
  input  logic             i2c_done,
  input  logic             i2c_ack,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int DLY_W = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(PWR_DLY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_NUM - 1);

  typedef enum logic [3:0] {
    WAIT_PWR,
    FETCH,
    WRITE,
    WAIT_WR,
`ifdef CMOS_CFG_VERIFY_EN
    READ,
    WAIT_RD,
`endif
    NEXT,
    DONE,
    ERROR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DLY_W-1:0] dly_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             fetch_second;
  logic             attempt_fail;
  logic             in_wait;
  logic             tx_start;
  logic             restart;

  // A done on the same cycle as the timeout wins; any failure funnels into the shared retry decision.
  always_comb begin
    state_next   = state;
    attempt_fail = 1'b0;
    in_wait      = 1'b0;
    tx_start     = 1'b0;
    restart      = 1'b0;
    i2c_exec     = 1'b0;
    i2c_rh_wl    = 1'b0;
    cfg_busy     = 1'b1;
    cfg_done     = 1'b0;
    cfg_err      = 1'b0;
    case (state)
      WAIT_PWR: if (dly_cnt == DLY_LAST) state_next = FETCH;
      FETCH:    if (fetch_second) state_next = WRITE;
      WRITE: begin
        i2c_exec   = 1'b1;
        tx_start   = 1'b1;
        state_next = WAIT_WR;
      end
      WAIT_WR: begin
        in_wait = 1'b1;
        if (i2c_done) begin
          if (i2c_ack) attempt_fail = 1'b1;
`ifdef CMOS_CFG_VERIFY_EN
          else state_next = READ;
`else
          else state_next = NEXT;
`endif
        end else if (tmo_cnt == TMO_LAST) begin
          attempt_fail = 1'b1;
        end
      end
`ifdef CMOS_CFG_VERIFY_EN
      READ: begin
        i2c_exec   = 1'b1;
        i2c_rh_wl  = 1'b1;
        tx_start   = 1'b1;
        state_next = WAIT_RD;
      end
      WAIT_RD: begin
        in_wait = 1'b1;
        if (i2c_done) begin
          if (i2c_ack || (i2c_data_r != i2c_data_w)) attempt_fail = 1'b1;
          else state_next = NEXT;
        end else if (tmo_cnt == TMO_LAST) begin
          attempt_fail = 1'b1;
        end
      end
`endif
      NEXT: state_next = (cfg_index == IDX_LAST) ? DONE : FETCH;
      DONE: begin
        cfg_busy = 1'b0;
        cfg_done = 1'b1;
        if (cfg_start) begin
          restart    = 1'b1;
          state_next = FETCH;
        end
      end
      ERROR: begin
        cfg_busy = 1'b0;
        cfg_err  = 1'b1;
        if (cfg_start) begin
          restart    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = WAIT_PWR;
    endcase
    if (attempt_fail) state_next = (retry_cnt == RTY_LAST) ? ERROR : WRITE;
  end

  // The address/value latch happens on the second FETCH cycle, once the table has answered the new index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= WAIT_PWR;
      dly_cnt      <= '0;
      tmo_cnt      <= '0;
      retry_cnt    <= '0;
      fetch_second <= 1'b0;
      cfg_index    <= '0;
      i2c_addr     <= '0;
      i2c_data_w   <= '0;
    end else begin
      state        <= state_next;
      fetch_second <= (state == FETCH) && !fetch_second;
      if ((state == WAIT_PWR) && (dly_cnt != DLY_LAST)) dly_cnt <= dly_cnt + DLY_W'(1);
      if ((state == FETCH) && fetch_second) begin
        i2c_addr   <= cfg_data[23:8];
        i2c_data_w <= cfg_data[7:0];
      end
      if (tx_start) tmo_cnt <= '0;
      else if (in_wait) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (attempt_fail) retry_cnt <= retry_cnt + RTY_W'(1);
      if (state == NEXT) begin
        retry_cnt <= '0;
        if (cfg_index != IDX_LAST) cfg_index <= cfg_index + IDX_W'(1);
      end
      if (restart) begin
        retry_cnt <= '0;
        cfg_index <= '0;
      end
    end
  end

`ifndef CMOS_CFG_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^i2c_data_r;
`endif

endmodule

// File: tb/tb_cmos_cfg_seq.sv
// Directed scoreboard bench for cmos_cfg_seq with a behavioural SCCB driver and register table.
module tb_cmos_cfg_seq;

  localparam int REG_NUM   = 4;
  localparam int IDX_W     = 8;
  localparam int PWR_DLY   = 8;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 32;
  localparam int RESP_DLY  = 5;
`ifdef CMOS_CFG_VERIFY_EN
  localparam int EPE = 2;
`else
  localparam int EPE = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [IDX_W-1:0] cfg_index;
  logic [23:0]      cfg_data = '0;
  logic             i2c_exec;
  logic             i2c_rh_wl;
  logic [15:0]      i2c_addr;
  logic [7:0]       i2c_data_w;
  logic [7:0]       i2c_data_r;
  logic             i2c_done;
  logic             i2c_ack;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic [24:0] exp_q[$];
  int          exec_cyc[$];
  int          exec_count = 0;
  int          last_exec_cyc = -1;

  logic [15:0] nack_addr = '0;
  int          nack_left = 0;
  logic        no_resp = 1'b0;
  logic [15:0] flip_addr = '0;
  int          flip_left = 0;
  logic        inject_done = 1'b0;
  int          pend_cnt = 0;
  logic        pend_ack = 1'b0;
  logic [7:0]  pend_rd = '0;
  logic [7:0]  last_wdata = '0;

  cmos_cfg_seq #(
    .REG_NUM(REG_NUM), .IDX_W(IDX_W), .PWR_DLY(PWR_DLY),
    .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_index(cfg_index),
    .cfg_data(cfg_data), .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl),
    .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register table with one cycle of read latency.
  always @(posedge clk) cfg_data <= {16'h3000 + 16'(cfg_index), 8'hA0 + 8'(cfg_index)};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] wr(input int n);
    return {1'b0, 16'h3000 + 16'(n), 8'hA0 + 8'(n)};
  endfunction

  function automatic logic [24:0] rd(input int n);
    return {1'b1, 16'h3000 + 16'(n), 8'hA0 + 8'(n)};
  endfunction

  task automatic push_ok(input int n);
    exp_q.push_back(wr(n));
`ifdef CMOS_CFG_VERIFY_EN
    exp_q.push_back(rd(n));
`endif
  endtask

  // Driver model and scoreboard consumer, both acting 1 time unit after each rising edge.
  initial begin
    logic [24:0] exp;
    i2c_done   = 1'b0;
    i2c_ack    = 1'b0;
    i2c_data_r = '0;
    forever begin
      @(posedge clk);
      #1;
      i2c_done = 1'b0;
      i2c_ack  = 1'b0;
      if (!rst_n) begin
        pend_cnt      = 0;
        last_exec_cyc = -1;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            i2c_done   = 1'b1;
            i2c_ack    = pend_ack;
            i2c_data_r = pend_rd;
          end
        end
        if (inject_done) begin
          i2c_done    = 1'b1;
          inject_done = 1'b0;
        end
        if (i2c_exec) begin
          exec_count++;
          exec_cyc.push_back(cyc);
          if (last_exec_cyc >= 0) check("exec_gap_ge4", 32'(cyc - last_exec_cyc >= 4), 1);
          last_exec_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_exec", {7'd0, i2c_rh_wl, i2c_addr, i2c_data_w}, 32'hFFFF_FFFF);
          end else begin
            exp = exp_q.pop_front();
            check("exec_tx", {7'd0, i2c_rh_wl, i2c_addr, i2c_data_w}, {7'd0, exp});
          end
          pend_ack = 1'b0;
          pend_cnt = RESP_DLY;
          if (!i2c_rh_wl) begin
            last_wdata = i2c_data_w;
            if (no_resp) begin
              pend_cnt = 0;
            end else if (nack_left > 0 && i2c_addr == nack_addr) begin
              nack_left--;
              pend_ack = 1'b1;
            end
          end else begin
            pend_rd = last_wdata;
            if (flip_left > 0 && i2c_addr == flip_addr) begin
              flip_left--;
              pend_rd = last_wdata ^ 8'h01;
            end
          end
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus_start();
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int k = 0;
    while (!(cfg_done || cfg_err) && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 32'(cfg_done || cfg_err), 1);
  endtask

  task automatic wait_execs(input string tag, input int target, input int bound);
    int k = 0;
    while (exec_count < target && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 32'(exec_count >= target), 1);
  endtask

  task automatic check_output_reset(input string tag);
    check({tag, "_busy"}, 32'(cfg_busy), 1);
    check({tag, "_done"}, 32'(cfg_done), 0);
    check({tag, "_err"}, 32'(cfg_err), 0);
    check({tag, "_exec"}, 32'(i2c_exec), 0);
    check({tag, "_rhwl"}, 32'(i2c_rh_wl), 0);
    check({tag, "_index"}, 32'(cfg_index), 0);
    check({tag, "_addr"}, 32'(i2c_addr), 0);
    check({tag, "_dataw"}, 32'(i2c_data_w), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rel;
    int n0;
    int s;
    $display("[TB] start");

    // Scenario 1: clean power-up sequence
    wait_cycles(3);
    check_output_reset("rst");
    for (int n = 0; n < REG_NUM; n++) push_ok(n);
    n0 = exec_cyc.size();
    rst_n = 1'b1;
    rel = cyc;
    wait_end("s1_end", 400);
    check("s1_first_exec_delay", 32'(exec_cyc[n0] - rel), 32'(PWR_DLY + 2));
    check("s1_done", 32'(cfg_done), 1);
    check("s1_err", 32'(cfg_err), 0);
    check("s1_busy", 32'(cfg_busy), 0);
    check("s1_index", 32'(cfg_index), 32'(REG_NUM - 1));
    check("s1_exec_count", 32'(exec_count), 32'(REG_NUM * EPE));
    check("s1_queue_empty", 32'(exp_q.size()), 0);

    // Scenario 2: entry 1 NACKed twice then accepted
    nack_addr = 16'h3001;
    nack_left = 2;
    push_ok(0);
    exp_q.push_back(wr(1));
    exp_q.push_back(wr(1));
    for (int n = 1; n < REG_NUM; n++) push_ok(n);
    apply_stimulus_start();
    check("s2_restart_done", 32'(cfg_done), 0);
    check("s2_restart_busy", 32'(cfg_busy), 1);
    check("s2_restart_index", 32'(cfg_index), 0);
    wait_end("s2_end", 400);
    check("s2_done", 32'(cfg_done), 1);
    check("s2_err", 32'(cfg_err), 0);
    check("s2_queue_empty", 32'(exp_q.size()), 0);

    // Scenario 3: entry 2 NACKed on every attempt, then re-init
    nack_addr = 16'h3002;
    nack_left = MAX_RETRY;
    push_ok(0);
    push_ok(1);
    for (int r = 0; r < MAX_RETRY; r++) exp_q.push_back(wr(2));
    apply_stimulus_start();
    wait_end("s3_end", 400);
    check("s3_err", 32'(cfg_err), 1);
    check("s3_done", 32'(cfg_done), 0);
    check("s3_busy", 32'(cfg_busy), 0);
    check("s3_index", 32'(cfg_index), 2);
    n0 = exec_count;
    wait_cycles(10);
    check("s3_no_exec_in_error", 32'(exec_count), 32'(n0));
    nack_left = 0;
    for (int n = 0; n < REG_NUM; n++) push_ok(n);
    n0 = exec_cyc.size();
    apply_stimulus_start();
    s = cyc;
    check("s3_restart_err", 32'(cfg_err), 0);
    wait_execs("s3_restart_exec_seen", n0 + 1, 10);
    check("s3_restart_exec_latency",
          32'((exec_cyc.size() > n0) && (exec_cyc[n0] - s >= 1) && (exec_cyc[n0] - s <= 3)), 1);
    wait_end("s3_end2", 400);
    check("s3_done2", 32'(cfg_done), 1);

    // Scenario 4: driver never answers entry 0
    no_resp = 1'b1;
    for (int r = 0; r < MAX_RETRY; r++) exp_q.push_back(wr(0));
    n0 = exec_cyc.size();
    apply_stimulus_start();
    wait_end("s4_end", 400);
    check("s4_err", 32'(cfg_err), 1);
    check("s4_index", 32'(cfg_index), 0);
    check("s4_exec_count", 32'(exec_cyc.size() - n0), 32'(MAX_RETRY));
    if (exec_cyc.size() >= n0 + 3) begin
      check("s4_retry_interval1", 32'(exec_cyc[n0 + 1] - exec_cyc[n0]), 32'(TIMEOUT + 1));
      check("s4_retry_interval2", 32'(exec_cyc[n0 + 2] - exec_cyc[n0 + 1]), 32'(TIMEOUT + 1));
    end
    no_resp = 1'b0;

    // Scenario 5: ignored start and stray done, then reset mid-transaction
    for (int n = 0; n < REG_NUM; n++) push_ok(n);
    n0 = exec_count;
    apply_stimulus_start();
    wait_execs("s5_first_exec", n0 + 1, 20);
    wait_cycles(1);
    apply_stimulus_start();
    check("s5_start_ignored_busy", 32'(cfg_busy), 1);
    wait_end("s5_end", 400);
    check("s5_done", 32'(cfg_done), 1);
    check("s5_exec_count", 32'(exec_count - n0), 32'(REG_NUM * EPE));
    inject_done = 1'b1;
    wait_cycles(5);
    check("s5_stray_done", 32'(cfg_done), 1);
    check("s5_stray_busy", 32'(cfg_busy), 0);
    check("s5_stray_index", 32'(cfg_index), 32'(REG_NUM - 1));
    check("s5_stray_queue", 32'(exp_q.size()), 0);
    push_ok(0);
    push_ok(1);
    exp_q.push_back(wr(2));
    n0 = exec_count;
    apply_stimulus_start();
    wait_execs("s5_reach_entry2", n0 + 2 * EPE + 1, 100);
    wait_cycles(1);
    rst_n = 1'b0;
    wait_cycles(2);
    check_output_reset("s5_rst");
    check("s5_rst_queue", 32'(exp_q.size()), 0);
    for (int n = 0; n < REG_NUM; n++) push_ok(n);
    n0 = exec_cyc.size();
    rst_n = 1'b1;
    rel = cyc;
    wait_end("s5_end2", 400);
    check("s5_rst_first_exec_delay", 32'(exec_cyc[n0] - rel), 32'(PWR_DLY + 2));
    check("s5_done2", 32'(cfg_done), 1);
    check("s5_queue_empty2", 32'(exp_q.size()), 0);

`ifdef CMOS_CFG_VERIFY_EN
    // Scenario 6: first read-back of entry 0 returns a corrupted value
    flip_addr = 16'h3000;
    flip_left = 1;
    exp_q.push_back(wr(0));
    exp_q.push_back(rd(0));
    exp_q.push_back(wr(0));
    exp_q.push_back(rd(0));
    for (int n = 1; n < REG_NUM; n++) push_ok(n);
    apply_stimulus_start();
    wait_end("s6_end", 400);
    check("s6_done", 32'(cfg_done), 1);
    check("s6_err", 32'(cfg_err), 0);
    check("s6_queue_empty", 32'(exp_q.size()), 0);
`endif

    wait_cycles(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
